// File: rtl/vector_sweep_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : vector_sweep_sequencer
// Description : Exhaustive ascending input sweep with settle, capture and
//               valid/ready record emission; abortable and back-pressurable.
// Revision    : 1.0 - initial release
// ============================================================================
module vector_sweep_sequencer #(
   parameter int N_IN          = 3,
   parameter int SETTLE_CYCLES = 1
) (
   input  logic            CK,
   input  logic            reset,
   input  logic            start,
   input  logic            abort,
   output logic [N_IN-1:0] dut_in,
   input  logic            dut_out,
   output logic            rec_valid,
   input  logic            rec_ready,
   output logic [N_IN-1:0] rec_vector,
   output logic            rec_response,
   output logic            busy,
   output logic            done,
   output logic            aborted,
   output logic [N_IN:0]   ones_count
);

   localparam int c_cnt_w = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(SETTLE_CYCLES - 1);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SETTLE  = 3'd1,
      ST_CAPTURE = 3'd2,
      ST_EMIT    = 3'd3,
      ST_FINISH  = 3'd4
   } state_t;

   state_t              r_state;
   state_t              w_state_next;
   logic [N_IN-1:0]     r_vector;
   logic [c_cnt_w-1:0]  r_cnt;
   logic                r_rec_response;
   logic [N_IN:0]       r_ones_count;
   logic                r_done;
   logic                r_aborted;

   logic                w_handshake;
   logic                w_last_vector;
   logic                w_abort;

   assign w_handshake   = (r_state == ST_EMIT) && rec_ready;
   assign w_last_vector = &r_vector;
   assign w_abort       = abort && (r_state != ST_IDLE);

   always_ff @(posedge CK or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Abort overrides every other transition once a sweep is running.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE:    if (start) w_state_next = ST_SETTLE;
         ST_SETTLE:  if (r_cnt == c_cnt_last) w_state_next = ST_CAPTURE;
         ST_CAPTURE: w_state_next = ST_EMIT;
         ST_EMIT:    if (w_handshake) w_state_next = w_last_vector ? ST_FINISH : ST_SETTLE;
         ST_FINISH:  w_state_next = ST_IDLE;
         default:    w_state_next = ST_IDLE;
      endcase
      if (w_abort) begin
         w_state_next = ST_IDLE;
      end
   end

   always_ff @(posedge CK or posedge reset) begin
      if (reset) begin
         r_vector       <= '0;
         r_cnt          <= '0;
         r_rec_response <= 1'b0;
         r_ones_count   <= '0;
         r_done         <= 1'b0;
         r_aborted      <= 1'b0;
      end else begin
         r_done    <= 1'b0;
         r_aborted <= 1'b0;
         if (w_abort) begin
            // Partial ones_count is kept so the logger can see how far it got.
            r_vector  <= '0;
            r_cnt     <= '0;
            r_aborted <= 1'b1;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (start) begin
                     r_vector     <= '0;
                     r_cnt        <= '0;
                     r_ones_count <= '0;
                  end
               end
               ST_SETTLE: begin
                  r_cnt <= r_cnt + c_cnt_w'(1);
               end
               ST_CAPTURE: begin
                  r_rec_response <= dut_out;
                  r_ones_count   <= r_ones_count + {{N_IN{1'b0}}, dut_out};
               end
               ST_EMIT: begin
                  if (w_handshake) begin
                     if (w_last_vector) begin
                        r_done <= 1'b1;
                     end else begin
                        r_vector <= r_vector + N_IN'(1);
                        r_cnt    <= '0;
                     end
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

   assign dut_in       = r_vector;
   assign rec_vector   = r_vector;
   assign rec_response = r_rec_response;
   assign rec_valid    = (r_state == ST_EMIT);
   assign busy         = (r_state != ST_IDLE);
   assign done         = r_done;
   assign aborted      = r_aborted;
   assign ones_count   = r_ones_count;

endmodule
`default_nettype wire

// File: tb/tb_vector_sweep_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_vector_sweep_sequencer
// Description : Directed bench for vector_sweep_sequencer (SETTLE 1 and 3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vector_sweep_sequencer;

   logic       CK = 1'b0;
   logic       reset = 1'b1;
   int         cyc = 0;
   int         n_checks = 0;
   int         n_fail = 0;

   // Instance A: SETTLE=1, response = dut_in[0]
   logic       start_a = 1'b0, abort_a = 1'b0, rec_ready_a = 1'b1;
   logic [2:0] dut_in_a, rec_vector_a;
   logic       dut_out_a, rec_valid_a, rec_response_a, busy_a, done_a, aborted_a;
   logic [3:0] ones_count_a;

   // Instance B: SETTLE=3, response = registered AND of inputs
   logic       start_b = 1'b0, abort_b = 1'b0, rec_ready_b = 1'b1;
   logic [2:0] dut_in_b, rec_vector_b;
   logic       dut_out_b = 1'b0, rec_valid_b, rec_response_b, busy_b, done_b, aborted_b;
   logic [3:0] ones_count_b;

   int rv[$];
   int rr[$];
   int rc[$];

   always #5 CK = ~CK;
   always @(posedge CK) cyc <= cyc + 1;

   assign dut_out_a = dut_in_a[0];
   always @(posedge CK) dut_out_b <= &dut_in_b;

   vector_sweep_sequencer #(.N_IN(3), .SETTLE_CYCLES(1)) u_dut_a (
      .CK(CK), .reset(reset), .start(start_a), .abort(abort_a),
      .dut_in(dut_in_a), .dut_out(dut_out_a),
      .rec_valid(rec_valid_a), .rec_ready(rec_ready_a),
      .rec_vector(rec_vector_a), .rec_response(rec_response_a),
      .busy(busy_a), .done(done_a), .aborted(aborted_a), .ones_count(ones_count_a)
   );

   vector_sweep_sequencer #(.N_IN(3), .SETTLE_CYCLES(3)) u_dut_b (
      .CK(CK), .reset(reset), .start(start_b), .abort(abort_b),
      .dut_in(dut_in_b), .dut_out(dut_out_b),
      .rec_valid(rec_valid_b), .rec_ready(rec_ready_b),
      .rec_vector(rec_vector_b), .rec_response(rec_response_b),
      .busy(busy_b), .done(done_b), .aborted(aborted_b), .ones_count(ones_count_b)
   );

   task automatic check_value(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   task automatic clear_records();
      rv.delete();
      rr.delete();
      rc.delete();
   endtask

   // Returns the cycle number of the negedge at which start was driven.
   task automatic start_sweep_a(output int k);
      @(negedge CK);
      start_a = 1'b1;
      k = cyc;
      @(negedge CK);
      start_a = 1'b0;
      check_value("start_busy", busy_a, 1);
      check_value("start_ones_clear", ones_count_a, 0);
   endtask

   task automatic run_a(input int stall_vec, input int stall_len, input bit poke_start,
                        output int done_cyc, output int stalled);
      bit seen;
      seen = 1'b0;
      stalled = 0;
      done_cyc = -1;
      for (int i = 0; i < 400 && !seen; i++) begin
         @(negedge CK);
         rec_ready_a = 1'b1;
         start_a = poke_start && busy_a && (dut_in_a == 3'd5);
         if (rec_valid_a && int'(rec_vector_a) == stall_vec && stalled < stall_len) begin
            rec_ready_a = 1'b0;
            stalled++;
         end
         if (rec_valid_a && rec_ready_a) begin
            rv.push_back(int'(rec_vector_a));
            rr.push_back(int'(rec_response_a));
            rc.push_back(cyc);
         end
         if (done_a) begin
            seen = 1'b1;
            done_cyc = cyc;
         end
      end
      start_a = 1'b0;
      rec_ready_a = 1'b1;
      if (!seen) check_value("sweep_timeout", 0, 1);
   endtask

   // mode 0: response = vector[0]; mode 1: response = AND of vector bits
   task automatic check_stream(input string tag, input int mode, input int gap);
      int exp_resp;
      check_value({tag, "_count"}, rv.size(), 8);
      for (int i = 0; i < rv.size(); i++) begin
         exp_resp = (mode == 0) ? (i % 2) : ((i == 7) ? 1 : 0);
         check_value({tag, "_vec"}, rv[i], i);
         check_value({tag, "_resp"}, rr[i], exp_resp);
         if (gap > 0 && i > 0) check_value({tag, "_gap"}, rc[i] - rc[i-1], gap);
      end
   endtask

   initial begin
      int k;
      int dc;
      int st;
      bit hit;

      // Reset state
      repeat (2) @(negedge CK);
      check_value("rst_dut_in", dut_in_a, 0);
      check_value("rst_valid", rec_valid_a, 0);
      check_value("rst_vector", rec_vector_a, 0);
      check_value("rst_resp", rec_response_a, 0);
      check_value("rst_busy", busy_a, 0);
      check_value("rst_done", done_a, 0);
      check_value("rst_aborted", aborted_a, 0);
      check_value("rst_ones", ones_count_a, 0);
      reset = 1'b0;

      // Abort in IDLE is ignored
      @(negedge CK);
      abort_a = 1'b1;
      @(negedge CK);
      abort_a = 1'b0;
      check_value("idle_abort_pulse", aborted_a, 0);
      check_value("idle_abort_busy", busy_a, 0);

      // Basic sweep, no backpressure
      clear_records();
      start_sweep_a(k);
      run_a(-1, 0, 1'b0, dc, st);
      check_stream("basic", 0, 3);
      check_value("basic_done_lat", dc - k, 25);
      check_value("basic_ones", ones_count_a, 4);
      @(negedge CK);
      check_value("basic_done_single", done_a, 0);
      check_value("basic_idle", busy_a, 0);

      // Back-to-back: start in the cycle after done
      clear_records();
      start_a = 1'b1;
      k = cyc;
      @(negedge CK);
      start_a = 1'b0;
      check_value("b2b_busy", busy_a, 1);
      check_value("b2b_ones_clear", ones_count_a, 0);
      run_a(-1, 0, 1'b0, dc, st);
      check_stream("b2b", 0, 3);
      check_value("b2b_done_lat", dc - k, 25);
      check_value("b2b_ones", ones_count_a, 4);

      // Backpressure on vector 010, start poked mid-sweep
      clear_records();
      start_sweep_a(k);
      run_a(2, 5, 1'b1, dc, st);
      check_stream("stall", 0, 0);
      check_value("stall_len", st, 5);
      check_value("stall_done_lat", dc - k, 30);
      check_value("stall_ones", ones_count_a, 4);

      // Abort coincident with handshake on 100; start+abort in IDLE starts
      @(negedge CK);
      start_a = 1'b1;
      abort_a = 1'b1;
      @(negedge CK);
      start_a = 1'b0;
      abort_a = 1'b0;
      check_value("sa_busy", busy_a, 1);
      check_value("sa_no_abort", aborted_a, 0);
      hit = 1'b0;
      for (int i = 0; i < 100 && !hit; i++) begin
         @(negedge CK);
         if (rec_valid_a && rec_vector_a == 3'd4) begin
            hit = 1'b1;
            abort_a = 1'b1;
            rec_ready_a = 1'b1;
         end
      end
      if (!hit) check_value("abort_timeout", 0, 1);
      @(negedge CK);
      abort_a = 1'b0;
      check_value("abort_pulse", aborted_a, 1);
      check_value("abort_busy", busy_a, 0);
      check_value("abort_dut_in", dut_in_a, 0);
      check_value("abort_valid", rec_valid_a, 0);
      check_value("abort_no_done", done_a, 0);
      check_value("abort_ones", ones_count_a, 2);
      @(negedge CK);
      check_value("abort_pulse_end", aborted_a, 0);
      check_value("abort_ones_hold", ones_count_a, 2);

      // Restart after abort
      clear_records();
      start_sweep_a(k);
      run_a(-1, 0, 1'b0, dc, st);
      check_value("restart_first", (rv.size() > 0) ? rv[0] : -1, 0);
      check_value("restart_count", rv.size(), 8);
      check_value("restart_ones", ones_count_a, 4);

      // Async reset mid-SETTLE of vector 011
      start_sweep_a(k);
      hit = 1'b0;
      for (int i = 0; i < 100 && !hit; i++) begin
         @(negedge CK);
         if (dut_in_a == 3'd3 && !rec_valid_a) hit = 1'b1;
      end
      if (!hit) check_value("rst_mid_timeout", 0, 1);
      #2;
      reset = 1'b1;
      start_a = 1'b1;
      #1;
      check_value("arst_dut_in", dut_in_a, 0);
      check_value("arst_vector", rec_vector_a, 0);
      check_value("arst_busy", busy_a, 0);
      check_value("arst_valid", rec_valid_a, 0);
      check_value("arst_ones", ones_count_a, 0);
      check_value("arst_resp", rec_response_a, 0);
      repeat (2) @(negedge CK);
      check_value("arst_start_ign", busy_a, 0);
      reset = 1'b0;
      start_a = 1'b0;
      @(negedge CK);
      check_value("arst_after_busy", busy_a, 0);
      check_value("arst_after_done", done_a, 0);
      check_value("arst_after_abort", aborted_a, 0);

      // SETTLE=3 with registered AND response
      clear_records();
      @(negedge CK);
      start_b = 1'b1;
      k = cyc;
      @(negedge CK);
      start_b = 1'b0;
      hit = 1'b0;
      dc = -1;
      for (int i = 0; i < 400 && !hit; i++) begin
         @(negedge CK);
         if (rec_valid_b && rec_ready_b) begin
            rv.push_back(int'(rec_vector_b));
            rr.push_back(int'(rec_response_b));
            rc.push_back(cyc);
         end
         if (done_b) begin
            hit = 1'b1;
            dc = cyc;
         end
      end
      if (!hit) check_value("settle3_timeout", 0, 1);
      check_stream("settle3", 1, 5);
      check_value("settle3_done_lat", dc - k, 41);
      check_value("settle3_ones", ones_count_b, 1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
